// File: rtl/sap1_controlador_sequenciador_if.sv
// rtl/sap1_controlador_sequenciador_if.sv - SAP-1 sequencer run/opcode inputs and control word bundle
interface sap1_controlador_sequenciador_if;
  logic       run;
  logic [3:0] opcode;
  logic       PC_INC, PC_OUT, MAR_IN, RAM_OUT, IR_IN, IR_OUT;
  logic       ACC_IN, ACC_OUT, B_IN, ULA_SUB, ULA_OUT, OUT_IN;
  logic [5:0] t_state;
  logic       halted;

  modport master (
    output run, opcode,
    input  PC_INC, PC_OUT, MAR_IN, RAM_OUT, IR_IN, IR_OUT,
    input  ACC_IN, ACC_OUT, B_IN, ULA_SUB, ULA_OUT, OUT_IN,
    input  t_state, halted
  );

  modport slave (
    input  run, opcode,
    output PC_INC, PC_OUT, MAR_IN, RAM_OUT, IR_IN, IR_OUT,
    output ACC_IN, ACC_OUT, B_IN, ULA_SUB, ULA_OUT, OUT_IN,
    output t_state, halted
  );
endinterface

// File: rtl/sap1_controlador_sequenciador.sv
// rtl/sap1_controlador_sequenciador.sv - SAP-1 one-hot T1..T6 ring counter and instruction decoder
module sap1_controlador_sequenciador (
  input logic                             clock,
  input logic                             clear,
  sap1_controlador_sequenciador_if.slave ctl
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef struct packed {
    logic pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out;
    logic acc_in, acc_out, b_in, ula_sub, ula_out, out_in;
  } ctrl_t;

  t_state_e t_state_q;
  logic     halted_q;
  ctrl_t    ctrl;

  // A corrupted ring is forced back to T1 even while run is low.
  always_ff @(posedge clock) begin
    if (!clear) begin
      t_state_q <= T1;
      halted_q  <= 1'b0;
    end else if (!$onehot(t_state_q)) begin
      t_state_q <= T1;
    end else if (ctl.run && !halted_q) begin
      if (t_state_q == T4 && ctl.opcode == OP_HLT) begin
        halted_q <= 1'b1;
      end else begin
        case (t_state_q)
          T1:      t_state_q <= T2;
          T2:      t_state_q <= T3;
          T3:      t_state_q <= T4;
          T4:      t_state_q <= T5;
          T5:      t_state_q <= T6;
          default: t_state_q <= T1;
        endcase
      end
    end
  end

  always_comb begin
    ctrl = '0;
    if (clear && ctl.run && !halted_q) begin
      case (t_state_q)
        T1: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; end
        T2: ctrl.pc_inc = 1'b1;
        T3: begin ctrl.ram_out = 1'b1; ctrl.ir_in = 1'b1; end
        T4: begin
          if (ctl.opcode == OP_LDA || ctl.opcode == OP_ADD || ctl.opcode == OP_SUB) begin
            ctrl.ir_out = 1'b1;
            ctrl.mar_in = 1'b1;
          end else if (ctl.opcode == OP_OUT) begin
            ctrl.acc_out = 1'b1;
            ctrl.out_in  = 1'b1;
          end
        end
        T5: begin
          if (ctl.opcode == OP_LDA) begin
            ctrl.ram_out = 1'b1;
            ctrl.acc_in  = 1'b1;
          end else if (ctl.opcode == OP_ADD || ctl.opcode == OP_SUB) begin
            ctrl.ram_out = 1'b1;
            ctrl.b_in    = 1'b1;
            ctrl.ula_sub = (ctl.opcode == OP_SUB);
          end
        end
        T6: begin
          if (ctl.opcode == OP_ADD || ctl.opcode == OP_SUB) begin
            ctrl.ula_out = 1'b1;
            ctrl.acc_in  = 1'b1;
            ctrl.ula_sub = (ctl.opcode == OP_SUB);
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign ctl.PC_INC  = ctrl.pc_inc;
  assign ctl.PC_OUT  = ctrl.pc_out;
  assign ctl.MAR_IN  = ctrl.mar_in;
  assign ctl.RAM_OUT = ctrl.ram_out;
  assign ctl.IR_IN   = ctrl.ir_in;
  assign ctl.IR_OUT  = ctrl.ir_out;
  assign ctl.ACC_IN  = ctrl.acc_in;
  assign ctl.ACC_OUT = ctrl.acc_out;
  assign ctl.B_IN    = ctrl.b_in;
  assign ctl.ULA_SUB = ctrl.ula_sub;
  assign ctl.ULA_OUT = ctrl.ula_out;
  assign ctl.OUT_IN  = ctrl.out_in;
  assign ctl.t_state = t_state_q;
  assign ctl.halted  = halted_q;

endmodule

// File: doc/sap1_controlador_sequenciador.md
# sap1_controlador_sequenciador

Control sequencer for the SAP-1 CPU. It is a six-state one-hot ring counter (T1–T6) combined with an instruction decoder. Each clock cycle it produces the control word that drives the program counter, MAR, RAM, instruction register, accumulator, B register, ULA and output register. It is the block that asserts `ACC_IN`/`ACC_OUT` on the accumulator, and it halts the machine on HLT.

## Interface
- No parameters. Word widths are fixed at 8-bit bus and 4-bit opcode.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  reset, synchronous, active-low.
- `run`  in  1  1 = sequencer advances; 0 = state frozen and control outputs forced to 0.
- `opcode`  in  4  upper nibble of the instruction register; valid from T4 onward.
- `PC_INC`, `PC_OUT`, `MAR_IN`, `RAM_OUT`, `IR_IN`, `IR_OUT`  out  1 each  active-high control signals.
- `ACC_IN`, `ACC_OUT`, `B_IN`, `ULA_SUB`, `ULA_OUT`, `OUT_IN`  out  1 each  active-high control signals.
- `t_state`  out  6  one-hot ring state; bit0 = T1 … bit5 = T6.
- `halted`  out  1  registered; 1 after HLT executes.

## Operation
- The ring register is the only state besides `halted`.
  - T1→T2→T3→T4→T5→T6→T1 on each edge where `clear`=1, `run`=1 and `halted`=0.
  - Every instruction takes exactly 6 cycles; there is no early termination.
- Control outputs are combinational from `t_state`, `opcode`, `run`, `halted` and `clear`.
  - All outputs are 0 when `clear`=0, `run`=0 or `halted`=1.
- Fetch cycle, identical for all opcodes:
  - T1: `PC_OUT`, `MAR_IN`.
  - T2: `PC_INC`.
  - T3: `RAM_OUT`, `IR_IN`.
- Execute cycle, decoded from `opcode`:
  - LDA 0000:
    - T4: `IR_OUT`, `MAR_IN`.
    - T5: `RAM_OUT`, `ACC_IN`.
    - T6: none.
  - ADD 0001:
    - T4: `IR_OUT`, `MAR_IN`.
    - T5: `RAM_OUT`, `B_IN`.
    - T6: `ULA_OUT`, `ACC_IN`.
  - SUB 0010: same as ADD, with `ULA_SUB` additionally asserted in T5 and T6.
  - OUT 1110:
    - T4: `ACC_OUT`, `OUT_IN`.
    - T5, T6: none.
  - HLT 1111:
    - T4: no control outputs.
    - The edge that ends T4 sets `halted`=1, and the ring stays at T4.
    - Only `clear`=0 leaves the halted state.
  - Any other opcode is a NOP: T4–T6 assert nothing, and the ring still cycles through them.
- Bus exclusivity: at most one of `PC_OUT`, `RAM_OUT`, `IR_OUT`, `ACC_OUT`, `ULA_OUT` is 1 in any cycle, for every opcode. This is a required assertion in verification.
- `opcode` is ignored during T1–T3.

## Timing
- Reset: an edge with `clear`=0 sets `t_state`=000001 (T1) and `halted`=0.
  - All control outputs read 0 for as long as `clear`=0.
  - Reset overrides `run` and `halted`.
  - Reset mid-instruction abandons that instruction; nothing is completed.
- After `clear` rises, the first cycle is T1 with `PC_OUT`=`MAR_IN`=1.
- `run`=0:
  - The ring holds its state.
  - Outputs go to 0 in the same cycle, so no register double-loads and the PC is not incremented twice.
  - When `run` returns to 1, the held T-state's outputs reappear and advance resumes on the next edge.
- HLT latency: `halted` rises 1 clock after entering T4 of the HLT instruction.
  - `t_state` then reads 001000 indefinitely.
- Per-instruction latency is 6 clocks from entering T1 to the next T1.
- `ACC_IN` is asserted for exactly one cycle per LDA/ADD/SUB.
  - The accumulator captures on the edge ending that cycle.
- The one-hot invariant must hold every cycle (exactly one bit of `t_state` set).
  - An illegal ring value must recover to T1 on the next edge (self-correcting decode).

## Test plan
- Reset and fetch: hold `clear`=0 for 2 cycles, then release with `run`=1.
  - `t_state` = 000001, 000010, 000100 over three cycles.
  - Outputs in those cycles: {`PC_OUT`,`MAR_IN`}, {`PC_INC`}, {`RAM_OUT`,`IR_IN`}.
- LDA/ADD/SUB: `opcode`=0000, then 0001, then 0010 across three instructions.
  - T4–T6 match the execute decode above.
  - `ULA_SUB`=1 only in T5/T6 of the SUB.
  - `ACC_IN` pulses once per instruction.
  - Bus-exclusivity assertion never fires.
- OUT then HLT: `opcode`=1110, then 1111.
  - OUT T4 shows `ACC_OUT`=`OUT_IN`=1.
  - On HLT, `halted`=1 one cycle after T4 and `t_state` is frozen at 001000 for 20 cycles with all outputs 0.
  - `clear`=0 then restarts at T1.
- `run` gating: drop `run` during T2 for 5 cycles.
  - `PC_INC`=0 while `run`=0.
  - State stays at T2, and exactly one `PC_INC` cycle occurs in total.
- Reset mid-operation: assert `clear`=0 during T5 of an ADD.
  - `ACC_IN`/`B_IN` are never asserted for that instruction.
  - The next cycle after release is T1.
- Unknown opcode 0101: T4–T6 assert no outputs, and the ring returns to T1 after 6 cycles.
